// File: rtl/apb_reg_bridge.sv
// -----------------------------------------------------------------------------
// apb_reg_bridge
//   Converts APB accesses into single-cycle register-bank request strobes and
//   returns the register side's response (data, error) on the APB bus. Accesses
//   to unmapped or misaligned addresses, and writes with no byte strobes, are
//   answered without touching the register side. A cycle budget (TIMEOUT)
//   bounds the wait for reg_ack; a dropped psel aborts the access.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   paddr           APB byte address
//   psel, penable   APB select / enable
//   pwrite          APB direction (1 = write)
//   pwdata, pstrb   APB write data and byte strobes
//   pready          transfer complete (registered)
//   prdata          read data, valid while pready=1 (registered)
//   pslverr         transfer error, valid while pready=1 (registered)
//   reg_addr        word index of the access
//   reg_wdata       write data towards the register bank
//   reg_be          byte enables (all ones on reads)
//   reg_wr, reg_rd  one-cycle request strobes
//   reg_rdata       register read data, sampled with reg_ack
//   reg_ack         register side done (may come with the strobe)
//   reg_err         register side error, qualified by reg_ack
// -----------------------------------------------------------------------------
module apb_reg_bridge #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 64,
  parameter int TIMEOUT  = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDR_W-1:0]                     paddr,
  input  logic                                  psel,
  input  logic                                  penable,
  input  logic                                  pwrite,
  input  logic [DATA_W-1:0]                     pwdata,
  input  logic [DATA_W/8-1:0]                   pstrb,
  output logic                                  pready,
  output logic [DATA_W-1:0]                     prdata,
  output logic                                  pslverr,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    reg_addr,
  output logic [DATA_W-1:0]                     reg_wdata,
  output logic [DATA_W/8-1:0]                   reg_be,
  output logic                                  reg_wr,
  output logic                                  reg_rd,
  input  logic [DATA_W-1:0]                     reg_rdata,
  input  logic                                  reg_ack,
  input  logic                                  reg_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = ADDR_W - LSB;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [63:0]       NUM_REGS_C = 64'(NUM_REGS);
  localparam logic [7:0]        TIMEOUT_C  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [7:0]          cnt_r;
  logic                write_r;
  logic                accept_s;
  logic                err_next_s;
  logic [DATA_W-1:0]   data_next_s;
  logic [IDX_W-1:0]    idx_s;
  logic                illegal_s;

  logic                pready_r;
  logic                pslverr_r;
  logic [DATA_W-1:0]   prdata_r;
  logic                reg_wr_r;
  logic                reg_rd_r;
  logic [IDX_W-1:0]    reg_addr_r;
  logic [DATA_W-1:0]   reg_wdata_r;
  logic [BYTES-1:0]    reg_be_r;

  // Address decode of the live APB address; only used when accepting in IDLE.
  // The alignment mask form avoids a zero-width slice when DATA_W is 8.
  assign idx_s     = IDX_W'(paddr >> LSB);
  assign illegal_s = ((paddr & ALIGN_MASK) != {ADDR_W{1'b0}}) ||
                     (64'(idx_s) >= NUM_REGS_C);

  // Next-state and response selection; response fields are only non-zero on
  // the transition into RESP so the output registers can load them directly.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    err_next_s   = 1'b0;
    data_next_s  = {DATA_W{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (psel && penable) begin
          accept_s = 1'b1;
          if (illegal_s) begin
            state_next_s = S_RESP;
            err_next_s   = 1'b1;
          end else if (pwrite && (pstrb == {BYTES{1'b0}})) begin
            // nothing to write: answer OK without a strobe
            state_next_s = S_RESP;
          end else begin
            state_next_s = S_REQ;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_REQ, S_WAIT: begin
        if (!psel) begin
          // master abort wins over any ack in the same cycle
          state_next_s = S_IDLE;
        end else if (reg_ack) begin
          state_next_s = S_RESP;
          err_next_s   = reg_err;
          if (!write_r && !reg_err) begin
            data_next_s = reg_rdata;
          end else begin
            data_next_s = {DATA_W{1'b0}};
          end
        end else if (cnt_r == TIMEOUT_C) begin
          state_next_s = S_RESP;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_RESP: begin
        // always drop back to IDLE; a new access is sampled no earlier than IDLE
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register and ack-wait counter (cleared on REQ entry, counts REQ/WAIT cycles).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s == S_REQ) begin
        cnt_r <= 8'd0;
      end else if ((state_r == S_REQ) || (state_r == S_WAIT)) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
    end
  end

  // Request fields are captured on acceptance and held until the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr_r  <= {IDX_W{1'b0}};
      reg_wdata_r <= {DATA_W{1'b0}};
      reg_be_r    <= {BYTES{1'b0}};
      write_r     <= 1'b0;
    end else if (accept_s) begin
      reg_addr_r  <= idx_s;
      reg_wdata_r <= pwdata;
      reg_be_r    <= pwrite ? pstrb : {BYTES{1'b1}};
      write_r     <= pwrite;
    end
  end

  // Registered strobes and APB response; strobes only fire on the IDLE->REQ edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_r  <= 1'b0;
      reg_rd_r  <= 1'b0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {DATA_W{1'b0}};
    end else begin
      reg_wr_r  <= (state_next_s == S_REQ) && pwrite;
      reg_rd_r  <= (state_next_s == S_REQ) && !pwrite;
      pready_r  <= (state_next_s == S_RESP);
      pslverr_r <= err_next_s;
      prdata_r  <= data_next_s;
    end
  end

  assign pready    = pready_r;
  assign pslverr   = pslverr_r;
  assign prdata    = prdata_r;
  assign reg_wr    = reg_wr_r;
  assign reg_rd    = reg_rd_r;
  assign reg_addr  = reg_addr_r;
  assign reg_wdata = reg_wdata_r;
  assign reg_be    = reg_be_r;

endmodule
